regfile_readback_scanner: RTL

Read-side companion to the register-file test sequencer. It walks the 16-entry register file through its read port, latching one register at a time. The latched 16-bit value is shown as four hex digits on the board's multiplexed seven-segment display. It sits beside the datapath and only observes it: it issues read addresses and never writes.

---
 rtl/regfile_readback_scanner_pkg.sv | 16 +
 rtl/regfile_readback_scanner_seg7.sv | 32 +++
 rtl/regfile_readback_scanner.sv | 123 ++++++++++++
 3 files changed

// File: rtl/regfile_readback_scanner_pkg.sv
// Shared encodings for the register-file read-back scanner:
// scan FSM states and display idle constants.
package regscan_pkg;

    typedef enum logic [1:0] {
        S_ADDR    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam int         REG_COUNT = 16;

endpackage

// File: rtl/regfile_readback_scanner_seg7.sv
// seg7_hex_decode: one hex nibble to active-low segments a..g,
// with segment a in bit 1 and segment g in bit 7.
module seg7_hex_decode
    import regscan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [1:7] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/regfile_readback_scanner.sv
// Walks the register file read port and shows each value on a 4-digit display.
// REGSCAN_AUTO_ADVANCE_EN adds a dwell-timeout advance beside the step input.
module regfile_readback_scanner
    import regscan_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int REFRESH_BITS = 16,
    parameter int LAST_REG     = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic [15:0] rd_data,
    output logic [3:0]  rd_addr,
    output logic [3:0]  cur_reg,
    output logic [15:0] shown,
    output logic [1:7]  cath,
    output logic [3:0]  an
);

    localparam logic [3:0] LAST = 4'(LAST_REG);

    if (DWELL_CYCLES < 4) begin : g_dwell_chk
        $error("DWELL_CYCLES must be at least 4");
    end
    if (LAST_REG >= REG_COUNT) begin : g_last_chk
        $error("LAST_REG must index an existing register");
    end

    scan_state_t             state;
    logic [3:0]              idx;
    logic                    step_q;
    logic                    step_edge;
    logic                    advance;
    logic                    blank;
    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              sel;
    logic [3:0]              nibble;
    logic [3:0]              an_sel;
    logic [1:7]              seg;

    assign step_edge = step & ~step_q;

`ifdef REGSCAN_AUTO_ADVANCE_EN
    localparam int DW = $clog2(DWELL_CYCLES);

    logic [DW-1:0] dwell;
    logic          timeout;

    assign timeout = (state == S_HOLD) && (dwell == DW'(DWELL_CYCLES - 1));
    assign advance = step_edge | timeout;

    // Restarts on every capture so each register gets a full dwell.
    always_ff @(posedge clk) begin
        if (reset)
            dwell <= '0;
        else if (state == S_CAPTURE)
            dwell <= '0;
        else if (state == S_HOLD && !timeout)
            dwell <= dwell + DW'(1);
    end
`else
    assign advance = step_edge;
`endif

    assign sel = refresh[REFRESH_BITS-1 -: 2];

    always_comb begin
        nibble = shown[3:0];
        an_sel = 4'b1110;
        unique case (sel)
            2'd0: begin nibble = shown[3:0];   an_sel = 4'b1110; end
            2'd1: begin nibble = shown[7:4];   an_sel = 4'b1101; end
            2'd2: begin nibble = shown[11:8];  an_sel = 4'b1011; end
            2'd3: begin nibble = shown[15:12]; an_sel = 4'b0111; end
        endcase
    end

    seg7_hex_decode u_dec (
        .hex (nibble),
        .seg (seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_ADDR;
            idx     <= 4'd0;
            rd_addr <= 4'd0;
            cur_reg <= 4'd0;
            shown   <= 16'd0;
            step_q  <= 1'b0;
            refresh <= '0;
            blank   <= 1'b1;
            an      <= AN_OFF;
            cath    <= SEG_BLANK;
        end else begin
            step_q  <= step;
            refresh <= refresh + REFRESH_BITS'(1);
            an      <= blank ? AN_OFF : an_sel;
            cath    <= blank ? SEG_BLANK : seg;
            unique case (state)
                S_ADDR: begin
                    rd_addr <= idx;
                    state   <= S_WAIT;
                end
                S_WAIT: state <= S_CAPTURE;
                S_CAPTURE: begin
                    shown   <= rd_data;
                    cur_reg <= rd_addr;
                    blank   <= 1'b0;
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (advance) begin
                        idx   <= (idx == LAST) ? 4'd0 : idx + 4'd1;
                        state <= S_ADDR;
                    end
                end
            endcase
        end
    end

endmodule
